// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit: owns HI/LO, runs a fixed-length busy window
// for mult/div, and serves mfhi/mflo reads combinationally.
module e_mdu #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        start,
   output logic        busy,
   output logic [31:0] out,
   output logic [31:0] hi_q,
   output logic [31:0] lo_q
);

   localparam int CNT_W = 4;

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MFHI  = 4'd5;
   localparam logic [3:0] OP_MFLO  = 4'd6;
   localparam logic [3:0] OP_MTHI  = 4'd7;
   localparam logic [3:0] OP_MTLO  = 4'd8;

   logic [31:0]      hi, lo;
   logic [31:0]      res_hi, res_lo;
   logic             res_div0;
   logic [CNT_W-1:0] cnt;

   logic signed [63:0] a_s64, b_s64, prod_s;
   logic        [63:0] a_u64, b_u64, prod_u;
   logic        [63:0] quot_s, quot_u;
   logic        [31:0] nxt_hi, nxt_lo;
   logic               nxt_div0;
   logic               is_md;

   // Returns {remainder, quotient}; the one overflowing case (-2^31 / -1) is pinned explicitly.
   function automatic logic [63:0] div_signed(input logic signed [31:0] n,
                                              input logic signed [31:0] d);
      if (d == 32'sd0)
         return 64'd0;
      else if (n == 32'sh8000_0000 && d == -32'sd1)
         return {32'h0000_0000, 32'h8000_0000};
      else
         return {n % d, n / d};
   endfunction

   function automatic logic [63:0] div_unsigned(input logic [31:0] n, input logic [31:0] d);
      if (d == 32'd0)
         return 64'd0;
      else
         return {n % d, n / d};
   endfunction

   assign a_s64  = {{32{A[31]}}, A};
   assign b_s64  = {{32{B[31]}}, B};
   assign prod_s = a_s64 * b_s64;
   assign a_u64  = {32'h0, A};
   assign b_u64  = {32'h0, B};
   assign prod_u = a_u64 * b_u64;
   assign quot_s = div_signed(A, B);
   assign quot_u = div_unsigned(A, B);

   always_comb begin
      is_md    = (op >= OP_MULT) && (op <= OP_DIVU);
      start    = is_md && !busy;
      nxt_hi   = 32'h0;
      nxt_lo   = 32'h0;
      nxt_div0 = 1'b0;
      case (op)
         OP_MULT:  {nxt_hi, nxt_lo} = prod_s;
         OP_MULTU: {nxt_hi, nxt_lo} = prod_u;
         OP_DIV: begin
            {nxt_hi, nxt_lo} = quot_s;
            nxt_div0         = (B == 32'h0);
         end
         OP_DIVU: begin
            {nxt_hi, nxt_lo} = quot_u;
            nxt_div0         = (B == 32'h0);
         end
         default: ;
      endcase
   end

   always_comb begin
      case (op)
         OP_MFHI: out = hi;
         OP_MFLO: out = lo;
         default: out = 32'h0;
      endcase
   end

   // Busy window: result is latched at start, committed to HI/LO on the last busy edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         hi       <= 32'h0;
         lo       <= 32'h0;
         res_hi   <= 32'h0;
         res_lo   <= 32'h0;
         res_div0 <= 1'b0;
         cnt      <= '0;
         busy     <= 1'b0;
      end else if (start) begin
         res_hi   <= nxt_hi;
         res_lo   <= nxt_lo;
         res_div0 <= nxt_div0;
         cnt      <= (op <= OP_MULTU) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
         busy     <= 1'b1;
      end else if (cnt != '0) begin
         cnt <= cnt - CNT_W'(1);
         if (cnt == CNT_W'(1)) begin
            busy <= 1'b0;
            if (!res_div0) begin
               hi <= res_hi;
               lo <= res_lo;
            end
         end
      end else if (!busy) begin
         if (op == OP_MTHI) hi <= A;
         if (op == OP_MTLO) lo <= A;
      end
   end

   assign hi_q = hi;
   assign lo_q = lo;

endmodule

// File: tb/tb_e_mdu.sv
// Bench for e_mdu: directed scenarios plus random op streams against a cycle-level
// model of the HI/LO unit computed with 64-bit integer arithmetic.
module tb_e_mdu;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  op;
   logic [31:0] A, B;
   logic        start, busy;
   logic [31:0] out, hi_q, lo_q;

   int checks = 0;
   int errors = 0;

   // reference state
   logic [31:0] m_hi, m_lo, p_hi, p_lo;
   bit          p_wr;
   int          m_left;

   e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk(clk), .rst(rst), .op(op), .A(A), .B(B),
      .start(start), .busy(busy), .out(out), .hi_q(hi_q), .lo_q(lo_q)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic void md_calc(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] rh, output logic [31:0] rl, output bit wr);
      longint          sa, sb, sq, sr;
      longint unsigned ua, ub, uq, ur;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'h0, a};
      ub = {32'h0, b};
      wr = 1'b1;
      rh = 32'h0;
      rl = 32'h0;
      case (o)
         4'd1: begin sq = sa * sb; rh = sq[63:32]; rl = sq[31:0]; end
         4'd2: begin uq = ua * ub; rh = uq[63:32]; rl = uq[31:0]; end
         4'd3: if (b == 0) wr = 1'b0;
               else begin sq = sa / sb; sr = sa % sb; rl = sq[31:0]; rh = sr[31:0]; end
         4'd4: if (b == 0) wr = 1'b0;
               else begin uq = ua / ub; ur = ua % ub; rl = uq[31:0]; rh = ur[31:0]; end
         default: ;
      endcase
   endfunction

   // One clock cycle: drive, check combinational/registered outputs mid-cycle, advance model.
   task automatic step(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic r = 1'b0);
      bit          md;
      logic [31:0] exp_out;
      op = o; A = a; B = b; rst = r;
      md = (o >= 1 && o <= 4);
      exp_out = (o == 5) ? m_hi : (o == 6) ? m_lo : 32'h0;
      @(negedge clk);
      chk("start", 32'(start), 32'(md && m_left == 0));
      chk("busy",  32'(busy),  32'(m_left > 0));
      chk("out",   out,  exp_out);
      chk("hi_q",  hi_q, m_hi);
      chk("lo_q",  lo_q, m_lo);
      @(posedge clk);
      if (r) begin
         m_hi = 0; m_lo = 0; m_left = 0; p_wr = 0;
      end else if (m_left > 0) begin
         m_left--;
         if (m_left == 0 && p_wr) begin m_hi = p_hi; m_lo = p_lo; end
      end else if (md) begin
         md_calc(o, a, b, p_hi, p_lo, p_wr);
         m_left = (o <= 2) ? 5 : 10;
      end else if (o == 7) m_hi = a;
      else if (o == 8) m_lo = a;
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(4'd0, 32'h0, 32'h0);
   endtask

   task automatic chk_hl(input string tag, input logic [31:0] eh, input logic [31:0] el);
      chk({tag, "_hi"}, hi_q, eh);
      chk({tag, "_lo"}, lo_q, el);
   endtask

   initial begin
      logic [3:0]  ro;
      logic [31:0] ra, rb;
      rst = 1'b1; op = 4'd0; A = 32'h0; B = 32'h0;
      m_hi = 0; m_lo = 0; m_left = 0; p_wr = 0; p_hi = 0; p_lo = 0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst_busy", 32'(busy), 32'h0);
      chk_hl("rst", 32'h0, 32'h0);

      step(4'd1, 32'hFFFF_FFFD, 32'd5);
      idle(5);
      chk_hl("mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFF1);
      step(4'd5, 32'h0, 32'h0);

      step(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      idle(5);
      chk_hl("multu_max", 32'hFFFF_FFFE, 32'h0000_0001);
      step(4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      idle(5);
      chk_hl("mult_m1", 32'h0, 32'h1);

      step(4'd3, 32'hFFFF_FFF9, 32'd2);
      idle(10);
      chk_hl("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      step(4'd4, 32'd7, 32'd2);
      idle(10);
      chk_hl("divu", 32'd1, 32'd3);
      step(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
      idle(10);
      chk_hl("div_ovf", 32'h0, 32'h8000_0000);

      step(4'd7, 32'h1234_5678, 32'h0);
      step(4'd3, 32'd5, 32'd0);
      idle(10);
      chk_hl("div0", 32'h1234_5678, 32'h8000_0000);

      step(4'd1, 32'd3, 32'd4);
      step(4'd8, 32'h0000_AAAA, 32'h0);
      step(4'd4, 32'd9, 32'd2);
      idle(3);
      chk_hl("busy_ign", 32'h0, 32'd12);
      step(4'd6, 32'h0, 32'h0);

      step(4'd3, 32'd100, 32'd7);
      idle(3);
      step(4'd0, 32'h0, 32'h0, 1'b1);
      chk_hl("rst_mid", 32'h0, 32'h0);
      idle(12);
      chk_hl("no_wb", 32'h0, 32'h0);

      for (int i = 0; i < 400; i++) begin
         ro = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 2) == 0) ro = 4'($urandom_range(1, 4));
         ra = $urandom;
         rb = $urandom;
         if ($urandom_range(0, 7) == 0) rb = 32'h0;
         if ($urandom_range(0, 9) == 0) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
         if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(1, 31);
         step(ro, ra, rb, ($urandom_range(0, 99) == 0));
      end
      idle(12);
      chk_hl("final", m_hi, m_lo);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/e_mdu.md
# e_mdu

Execute-stage multiply/divide unit for the five-stage MIPS pipeline. It consumes the forwarded rs/rt operands and the decoded MD operation of the instruction currently held in the D/E pipeline register. It owns the HI/LO registers and runs a multi-cycle busy window for mult/multu/div/divu. It exports `start`/`busy` to the hazard unit for stall generation, and `out` (HI/LO read data) to the E-stage result mux for mfhi/mflo.

## Interface
- MULT_CYCLES, 5, busy length in cycles for mult/multu
- DIV_CYCLES, 10, busy length in cycles for div/divu
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, synchronous, active-high
- op  in  4  MD operation: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO; 9–15 treated as NONE
- A  in  32  forwarded rs value (E stage)
- B  in  32  forwarded rt value (E stage)
- start  out  1  combinational: op ∈ {1..4} && !busy
- busy  out  1  registered: operation in progress
- out  out  32  combinational: HI if op=MFHI, LO if op=MFLO, else 0
- HI, LO are internal 32-bit registers. Also exported as hi_q/lo_q, out 32 each, for debug/bench visibility.

## Operation
- State: HI, LO, cnt (4 bits, sized for max(MULT_CYCLES,DIV_CYCLES)), busy, res_hi/res_lo (pending result).
- Start edge (start=1): compute the result from A/B and latch it into res_hi/res_lo. Set cnt ← MULT_CYCLES or DIV_CYCLES, busy ← 1. HI/LO are unchanged at this edge.
- MULT: {res_hi,res_lo} = signed(A)×signed(B), 64-bit.
- MULTU: {res_hi,res_lo} = unsigned(A)×unsigned(B), 64-bit.
- DIV: res_lo = signed quotient, truncated toward zero; res_hi = remainder, which takes the sign of the dividend.
- DIVU: unsigned quotient and remainder.
- Divide by zero (B=0, DIV/DIVU): busy runs the full DIV_CYCLES. At completion, HI and LO keep their prior values.
- 0x80000000 DIV 0xFFFFFFFF: LO=0x80000000, HI=0.
- Each edge with cnt>0: cnt ← cnt−1.
  - At the edge where cnt=1: HI ← res_hi, LO ← res_lo (except divide by zero), busy ← 0.
- MTHI/MTLO with busy=0: HI ← A or LO ← A at the edge.
  - MTHI/MTLO with busy=1: ignored. The hazard unit guarantees this does not occur, but the block defines the behaviour anyway.
- MD ops (1–4) arriving while busy=1: ignored, start=0. The hazard unit stalls them.
- MFHI/MFLO while busy=1: out returns the current (stale) HI/LO. The hazard unit must stall on (start||busy) for any op 1–8.
- rst: HI=0, LO=0, cnt=0, busy=0, res_hi=res_lo=0 at the next edge. Any in-flight result is discarded. rst has priority over start and over completion in the same cycle.

## Timing
- Reset values: busy=0, hi_q=0, lo_q=0. start=0 and out=0 whenever op=NONE.
- Start in cycle T leads to:
  - busy=1 in cycles T+1 … T+N, where N=MULT_CYCLES or DIV_CYCLES;
  - busy=0 in cycle T+N+1;
  - new HI/LO visible on hi_q/lo_q/out from cycle T+N+1.
- start and busy are never both 1. A back-to-back MD op issued in cycle T+N+1 starts normally.
- MTHI/MTLO in cycle T: new value is visible from cycle T+1. An MFHI in the same cycle as an MTHI returns the old HI.
- out is zero-latency from op/HI/LO. There is no registered output path.

## Test plan
- rst, then op=MULT, A=0xFFFFFFFD (−3), B=5 → start=1 for 1 cycle; busy=1 for exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFF1; MFHI out=0xFFFFFFFF.
- MULTU A=B=0xFFFFFFFF → after 5 busy cycles HI=0xFFFFFFFE, LO=0x00000001. Then MULT with the same operands → HI=0, LO=1.
- DIV A=0xFFFFFFF9 (−7), B=2 → busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU A=7, B=2 → LO=3, HI=1. DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- MTHI A=0x12345678, then DIV A=5, B=0 → busy 10 cycles; HI stays 0x12345678 and LO keeps its prior value.
- MULT started, then MTLO A=0xAAAA and DIVU issued while busy → both ignored, start=0. The final HI/LO equal the MULT result, and busy drops after exactly 5 cycles.
- DIV started, rst asserted in busy cycle 4 → next cycle busy=0, HI=LO=0. No later write-back of the discarded quotient.
